// File: rtl/tlb_assoc_pkg.sv
// Shared defaults and types for the fully-associative TLB.
// The address-width defaults are the values the old header macros provided.
package tlb_assoc_pkg;

    localparam int VIRT_ADDR_WIDTH = 32;
    localparam int PHY_ADDR_WIDTH  = 20;
    localparam int PAGE_SIZE       = 12;
    localparam int TLB_NUM_ENTRIES = 4;

    // Which rule picked the fill target.
    typedef enum logic [1:0] {
        VICTIM_MATCH   = 2'd0,
        VICTIM_INVALID = 2'd1,
        VICTIM_RR      = 2'd2
    } victim_src_e;

endpackage

// File: rtl/tlb_victim_sel.sv
// Fill target selection.
// Order of preference: existing tag match, then the lowest free slot, then the round-robin pointer.
module tlb_victim_sel
    import tlb_assoc_pkg::*;
#(
    parameter int NUM_ENTRIES = TLB_NUM_ENTRIES,
    localparam int IDX_W      = $clog2(NUM_ENTRIES)
) (
    input  logic [NUM_ENTRIES-1:0] valid_vec,
    input  logic [NUM_ENTRIES-1:0] match_vec,
    input  logic [IDX_W-1:0]       rr_ptr,
    output logic [IDX_W-1:0]       fill_idx,
    output logic                   advance_rr
);

    logic [IDX_W-1:0] match_idx;
    logic [IDX_W-1:0] free_idx;
    logic             match_any;
    logic             free_any;
    victim_src_e      victim_src;

    // Descending scan so the lowest qualifying index is the one left standing.
    always_comb begin
        match_idx = '0;
        free_idx  = '0;
        match_any = 1'b0;
        free_any  = 1'b0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (match_vec[i]) begin
                match_any = 1'b1;
                match_idx = IDX_W'(i);
            end
            if (!valid_vec[i]) begin
                free_any = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        if (match_any) begin
            victim_src = VICTIM_MATCH;
        end else if (free_any) begin
            victim_src = VICTIM_INVALID;
        end else begin
            victim_src = VICTIM_RR;
        end
    end

    always_comb begin
        fill_idx   = rr_ptr;
        advance_rr = 1'b0;
        case (victim_src)
            VICTIM_MATCH:   fill_idx = match_idx;
            VICTIM_INVALID: fill_idx = free_idx;
            default: begin
                fill_idx   = rr_ptr;
                advance_rr = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/tlb_assoc.sv
// Parametrised fully-associative TLB.
// Registered lookup with hit/miss flags, deduplicating fill, global flush, and identity bypass.
module tlb_assoc
    import tlb_assoc_pkg::*;
#(
    parameter int VA_W        = VIRT_ADDR_WIDTH,
    parameter int PA_W        = PHY_ADDR_WIDTH,
    parameter int PAGE_BITS   = PAGE_SIZE,
    parameter int NUM_ENTRIES = TLB_NUM_ENTRIES
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      lookup_valid,
    input  logic [VA_W-1:0]           virt_addr,
    input  logic                      trans_en,
    input  logic                      fill_valid,
    input  logic [VA_W-PAGE_BITS-1:0] fill_vpn,
    input  logic [PA_W-PAGE_BITS-1:0] fill_ppn,
    input  logic                      flush,
    output logic                      resp_valid,
    output logic [PA_W-1:0]           phys_addr,
    output logic                      tlb_hit,
    output logic                      tlb_miss
);

    localparam int VPN_W = VA_W - PAGE_BITS;
    localparam int PPN_W = PA_W - PAGE_BITS;
    localparam int IDX_W = $clog2(NUM_ENTRIES);

    logic [VPN_W-1:0]       tag_reg [NUM_ENTRIES];
    logic [PPN_W-1:0]       ppn_reg [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] valid_reg;
    logic [IDX_W-1:0]       rr_ptr_reg;

    logic                   resp_valid_reg;
    logic [PA_W-1:0]        phys_addr_reg;
    logic                   tlb_hit_reg;
    logic                   tlb_miss_reg;

    logic [VPN_W-1:0]       lookup_vpn;
    logic [NUM_ENTRIES-1:0] lookup_match;
    logic [NUM_ENTRIES-1:0] fill_match;
    logic                   lookup_any;
    logic [IDX_W-1:0]       lookup_idx;
    logic [IDX_W-1:0]       fill_idx;
    logic                   advance_rr;
    logic                   fill_we;

    assign lookup_vpn = virt_addr[VA_W-1:PAGE_BITS];

    // One lookup and one fill comparator per entry, both against pre-update state.
    for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_cmp
        assign lookup_match[gi] = valid_reg[gi] && (tag_reg[gi] == lookup_vpn);
        assign fill_match[gi]   = valid_reg[gi] && (tag_reg[gi] == fill_vpn);
    end

    always_comb begin
        lookup_any = 1'b0;
        lookup_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (lookup_match[i]) begin
                lookup_any = 1'b1;
                lookup_idx = IDX_W'(i);
            end
        end
    end

    tlb_victim_sel #(
        .NUM_ENTRIES (NUM_ENTRIES)
    ) u_victim_sel (
        .valid_vec  (valid_reg),
        .match_vec  (fill_match),
        .rr_ptr     (rr_ptr_reg),
        .fill_idx   (fill_idx),
        .advance_rr (advance_rr)
    );

    // Flush takes priority over a fill in the same cycle.
    assign fill_we = fill_valid && !flush && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_reg  <= '0;
            rr_ptr_reg <= '0;
        end else if (flush) begin
            valid_reg  <= '0;
            rr_ptr_reg <= '0;
        end else if (fill_valid) begin
            valid_reg[fill_idx] <= 1'b1;
            if (advance_rr) begin
                rr_ptr_reg <= rr_ptr_reg + 1'b1;
            end
        end
    end

    // Tag and translation storage carries no reset; valid_reg alone qualifies it.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_reg[fill_idx] <= fill_vpn;
            ppn_reg[fill_idx] <= fill_ppn;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid_reg <= 1'b0;
            phys_addr_reg  <= '0;
            tlb_hit_reg    <= 1'b0;
            tlb_miss_reg   <= 1'b0;
        end else begin
            resp_valid_reg <= lookup_valid;
            tlb_hit_reg    <= 1'b0;
            tlb_miss_reg   <= 1'b0;
            if (lookup_valid) begin
                if (!trans_en) begin
                    tlb_hit_reg   <= 1'b1;
                    phys_addr_reg <= virt_addr[PA_W-1:0];
                end else if (lookup_any) begin
                    tlb_hit_reg   <= 1'b1;
                    phys_addr_reg <= {ppn_reg[lookup_idx], virt_addr[PAGE_BITS-1:0]};
                end else begin
                    tlb_miss_reg  <= 1'b1;
                end
            end
        end
    end

    assign resp_valid = resp_valid_reg;
    assign phys_addr  = phys_addr_reg;
    assign tlb_hit    = tlb_hit_reg;
    assign tlb_miss   = tlb_miss_reg;

endmodule

// File: tb/tb_tlb_assoc.sv
// Directed bench for tlb_assoc: hand-computed responses for lookup, fill, replacement, flush and bypass.
module tb_tlb_assoc;

    logic        clk = 1'b0;
    logic        reset;
    logic        lookup_valid;
    logic [31:0] virt_addr;
    logic        trans_en;
    logic        fill_valid;
    logic [19:0] fill_vpn;
    logic [7:0]  fill_ppn;
    logic        flush;
    logic        resp_valid;
    logic [19:0] phys_addr;
    logic        tlb_hit;
    logic        tlb_miss;

    int vectors     = 0;
    int miscompares = 0;

    tlb_assoc dut (
        .clk          (clk),
        .reset        (reset),
        .lookup_valid (lookup_valid),
        .virt_addr    (virt_addr),
        .trans_en     (trans_en),
        .fill_valid   (fill_valid),
        .fill_vpn     (fill_vpn),
        .fill_ppn     (fill_ppn),
        .flush        (flush),
        .resp_valid   (resp_valid),
        .phys_addr    (phys_addr),
        .tlb_hit      (tlb_hit),
        .tlb_miss     (tlb_miss)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [31:0] va, input logic te);
        lookup_valid = 1'b1;
        virt_addr    = va;
        trans_en     = te;
        cycle();
        lookup_valid = 1'b0;
        trans_en     = 1'b1;
        $display("lookup va=%h te=%0d -> valid=%0d hit=%0d miss=%0d pa=%h",
                 va, te, resp_valid, tlb_hit, tlb_miss, phys_addr);
    endtask

    task automatic fill(input logic [19:0] vpn, input logic [7:0] ppn);
        fill_valid = 1'b1;
        fill_vpn   = vpn;
        fill_ppn   = ppn;
        cycle();
        fill_valid = 1'b0;
        $display("fill vpn=%h ppn=%h", vpn, ppn);
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        lookup_valid = 1'b1;
        virt_addr    = 32'h0011_0ABC;
        fill_valid   = 1'b1;
        fill_vpn     = 20'h00110;
        fill_ppn     = 8'hAB;
        cycle();
        cycle();
        lookup_valid = 1'b0;
        fill_valid   = 1'b0;
        $display("reset held -> valid=%0d hit=%0d miss=%0d pa=%h", resp_valid, tlb_hit, tlb_miss, phys_addr);
        vectors++;
        if (resp_valid !== 1'b0 || tlb_hit !== 1'b0 || tlb_miss !== 1'b0 || phys_addr !== 20'h0) begin
            miscompares++;
            $display("FAIL reset_state: got v=%0d h=%0d m=%0d pa=%h, want 0 0 0 00000",
                     resp_valid, tlb_hit, tlb_miss, phys_addr);
        end
        reset = 1'b0;
        lookup(32'h0011_0ABC, 1'b1);
        vectors++;
        if (resp_valid !== 1'b1 || tlb_hit !== 1'b0 || tlb_miss !== 1'b1 || phys_addr !== 20'h0) begin
            miscompares++;
            $display("FAIL first_miss: got v=%0d h=%0d m=%0d pa=%h, want 1 0 1 00000",
                     resp_valid, tlb_hit, tlb_miss, phys_addr);
        end
        cycle();
        vectors++;
        if (resp_valid !== 1'b0 || tlb_hit !== 1'b0 || tlb_miss !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_no_resp: got v=%0d h=%0d m=%0d, want 0 0 0", resp_valid, tlb_hit, tlb_miss);
        end
    endtask

    task automatic test_fill_hit();
        fill(20'h00110, 8'hAB);
        lookup(32'h0011_0ABC, 1'b1);
        vectors++;
        if (resp_valid !== 1'b1 || tlb_hit !== 1'b1 || tlb_miss !== 1'b0 || phys_addr !== 20'hABABC) begin
            miscompares++;
            $display("FAIL fill_hit: got v=%0d h=%0d m=%0d pa=%h, want 1 1 0 ababc",
                     resp_valid, tlb_hit, tlb_miss, phys_addr);
        end
    endtask

    task automatic test_mid_reset();
        lookup_valid = 1'b1;
        virt_addr    = 32'h0011_0ABC;
        reset        = 1'b1;
        cycle();
        lookup_valid = 1'b0;
        reset        = 1'b0;
        vectors++;
        if (resp_valid !== 1'b0 || tlb_hit !== 1'b0 || phys_addr !== 20'h0) begin
            miscompares++;
            $display("FAIL mid_reset_drop: got v=%0d h=%0d pa=%h, want 0 0 00000", resp_valid, tlb_hit, phys_addr);
        end
        lookup(32'h0011_0ABC, 1'b1);
        vectors++;
        if (tlb_hit !== 1'b0 || tlb_miss !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_invalidates: got h=%0d m=%0d, want 0 1", tlb_hit, tlb_miss);
        end
    endtask

    task automatic test_rr_replace();
        for (int i = 0; i < 4; i++) fill(20'h00100 + 20'(i), 8'h10 + 8'(i));
        for (int i = 0; i < 4; i++) begin
            lookup({20'h00100 + 20'(i), 12'h123}, 1'b1);
            vectors++;
            if (tlb_hit !== 1'b1 || phys_addr !== {8'h10 + 8'(i), 12'h123}) begin
                miscompares++;
                $display("FAIL fill4_hit[%0d]: got h=%0d pa=%h, want 1 %h", i, tlb_hit, phys_addr,
                         {8'h10 + 8'(i), 12'h123});
            end
        end
        fill(20'h00104, 8'h14);
        lookup(32'h0010_0123, 1'b1);
        vectors++;
        if (tlb_miss !== 1'b1 || tlb_hit !== 1'b0 || phys_addr !== 20'h13123) begin
            miscompares++;
            $display("FAIL evict_idx0: got h=%0d m=%0d pa=%h, want 0 1 13123", tlb_hit, tlb_miss, phys_addr);
        end
        lookup(32'h0010_4123, 1'b1);
        vectors++;
        if (tlb_hit !== 1'b1 || phys_addr !== 20'h14123) begin
            miscompares++;
            $display("FAIL fifth_hit: got h=%0d pa=%h, want 1 14123", tlb_hit, phys_addr);
        end
        fill(20'h00105, 8'h15);
        lookup(32'h0010_1123, 1'b1);
        vectors++;
        if (tlb_miss !== 1'b1 || phys_addr !== 20'h14123) begin
            miscompares++;
            $display("FAIL evict_idx1: got m=%0d pa=%h, want 1 14123", tlb_miss, phys_addr);
        end
        lookup(32'h0010_2123, 1'b1);
        vectors++;
        if (tlb_hit !== 1'b1 || phys_addr !== 20'h12123) begin
            miscompares++;
            $display("FAIL idx2_kept: got h=%0d pa=%h, want 1 12123", tlb_hit, phys_addr);
        end
    endtask

    task automatic test_refill();
        fill(20'h00102, 8'h3C);
        lookup(32'h0010_2123, 1'b1);
        vectors++;
        if (tlb_hit !== 1'b1 || phys_addr !== 20'h3C123) begin
            miscompares++;
            $display("FAIL refill_new_ppn: got h=%0d pa=%h, want 1 3c123", tlb_hit, phys_addr);
        end
        // rr_ptr must still be 2, so the next new VPN evicts 0x00102 and leaves 0x00103.
        fill(20'h00106, 8'h16);
        lookup(32'h0010_2123, 1'b1);
        vectors++;
        if (tlb_miss !== 1'b1 || phys_addr !== 20'h3C123) begin
            miscompares++;
            $display("FAIL refill_rr_hold_evict: got m=%0d pa=%h, want 1 3c123", tlb_miss, phys_addr);
        end
        lookup(32'h0010_3123, 1'b1);
        vectors++;
        if (tlb_hit !== 1'b1 || phys_addr !== 20'h13123) begin
            miscompares++;
            $display("FAIL refill_rr_hold_keep: got h=%0d pa=%h, want 1 13123", tlb_hit, phys_addr);
        end
    endtask

    task automatic test_flush_fill();
        flush      = 1'b1;
        fill_valid = 1'b1;
        fill_vpn   = 20'h00200;
        fill_ppn   = 8'h20;
        cycle();
        flush      = 1'b0;
        fill_valid = 1'b0;
        lookup(32'h0020_0123, 1'b1);
        vectors++;
        if (tlb_miss !== 1'b1 || phys_addr !== 20'h13123) begin
            miscompares++;
            $display("FAIL flush_drops_fill: got m=%0d pa=%h, want 1 13123", tlb_miss, phys_addr);
        end
        lookup(32'h0010_3123, 1'b1);
        vectors++;
        if (tlb_miss !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_clears: got m=%0d, want 1", tlb_miss);
        end
        // rr_ptr was 3 before the flush; after reset to 0 the fifth fill evicts 0x00300.
        for (int i = 0; i < 5; i++) fill(20'h00300 + 20'(i), 8'h30 + 8'(i));
        lookup(32'h0030_0123, 1'b1);
        vectors++;
        if (tlb_miss !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_rr_reset_evict: got m=%0d, want 1", tlb_miss);
        end
        lookup(32'h0030_3123, 1'b1);
        vectors++;
        if (tlb_hit !== 1'b1 || phys_addr !== 20'h33123) begin
            miscompares++;
            $display("FAIL flush_rr_reset_keep: got h=%0d pa=%h, want 1 33123", tlb_hit, phys_addr);
        end
    endtask

    task automatic test_fill_lookup_same();
        fill_valid = 1'b1;
        fill_vpn   = 20'h00400;
        fill_ppn   = 8'h40;
        lookup(32'h0040_0123, 1'b1);
        fill_valid = 1'b0;
        vectors++;
        if (resp_valid !== 1'b1 || tlb_miss !== 1'b1 || tlb_hit !== 1'b0) begin
            miscompares++;
            $display("FAIL same_cycle_fill_lookup: got v=%0d h=%0d m=%0d, want 1 0 1",
                     resp_valid, tlb_hit, tlb_miss);
        end
        lookup(32'h0040_0123, 1'b1);
        vectors++;
        if (tlb_hit !== 1'b1 || phys_addr !== 20'h40123) begin
            miscompares++;
            $display("FAIL lookup_after_fill: got h=%0d pa=%h, want 1 40123", tlb_hit, phys_addr);
        end
    endtask

    task automatic test_flush_lookup();
        flush = 1'b1;
        lookup(32'h0040_0ABC, 1'b1);
        flush = 1'b0;
        vectors++;
        if (tlb_hit !== 1'b1 || phys_addr !== 20'h40ABC) begin
            miscompares++;
            $display("FAIL flush_lookup_preflush: got h=%0d pa=%h, want 1 40abc", tlb_hit, phys_addr);
        end
        lookup(32'h0040_0ABC, 1'b1);
        vectors++;
        if (tlb_miss !== 1'b1 || phys_addr !== 20'h40ABC) begin
            miscompares++;
            $display("FAIL flush_lookup_after: got m=%0d pa=%h, want 1 40abc", tlb_miss, phys_addr);
        end
    endtask

    task automatic test_bypass();
        lookup(32'h1234_5678, 1'b0);
        vectors++;
        if (resp_valid !== 1'b1 || tlb_hit !== 1'b1 || tlb_miss !== 1'b0 || phys_addr !== 20'h45678) begin
            miscompares++;
            $display("FAIL bypass: got v=%0d h=%0d m=%0d pa=%h, want 1 1 0 45678",
                     resp_valid, tlb_hit, tlb_miss, phys_addr);
        end
    endtask

    task automatic test_back_to_back();
        fill(20'h00500, 8'h50);
        fill(20'h00501, 8'h51);
        lookup(32'h0050_0ABC, 1'b1);
        vectors++;
        if (tlb_hit !== 1'b1 || phys_addr !== 20'h50ABC) begin
            miscompares++;
            $display("FAIL b2b_0: got h=%0d pa=%h, want 1 50abc", tlb_hit, phys_addr);
        end
        lookup(32'h0050_1DEF, 1'b1);
        vectors++;
        if (tlb_hit !== 1'b1 || phys_addr !== 20'h51DEF) begin
            miscompares++;
            $display("FAIL b2b_1: got h=%0d pa=%h, want 1 51def", tlb_hit, phys_addr);
        end
        lookup(32'h0099_9000, 1'b1);
        vectors++;
        if (resp_valid !== 1'b1 || tlb_miss !== 1'b1 || phys_addr !== 20'h51DEF) begin
            miscompares++;
            $display("FAIL b2b_2: got v=%0d m=%0d pa=%h, want 1 1 51def", resp_valid, tlb_miss, phys_addr);
        end
        cycle();
        vectors++;
        if (resp_valid !== 1'b0 || tlb_miss !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_idle: got v=%0d m=%0d, want 0 0", resp_valid, tlb_miss);
        end
    endtask

    initial begin
        reset        = 1'b1;
        lookup_valid = 1'b0;
        virt_addr    = '0;
        trans_en     = 1'b1;
        fill_valid   = 1'b0;
        fill_vpn     = '0;
        fill_ppn     = '0;
        flush        = 1'b0;
        cycle();
        test_reset();
        test_fill_hit();
        test_mid_reset();
        test_rr_replace();
        test_refill();
        test_flush_fill();
        test_fill_lookup_same();
        test_flush_lookup();
        test_bypass();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
